// File: rtl/jt7759_dfifo.sv
// rtl/jt7759_dfifo.sv - jt7759 sample-data FIFO feeder
// ROM prefetcher (master) or CPU-filled FIFO with DRQ pacing (slave) in front of the ADPCM sequencer.
module jt7759_dfifo #(
   parameter int DW       = 8,
   parameter int AW       = 17,
   parameter int DEPTH    = 4,
   parameter int DRQ_HOLD = 3,
   parameter int LW       = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cen4,
   input  logic          mdn,
   input  logic          flush,
   input  logic          ctrl_cs,
   input  logic [AW-1:0] ctrl_addr,
   output logic [DW-1:0] ctrl_din,
   output logic          ctrl_ok,
   output logic          rom_cs,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   input  logic          rom_ok,
   input  logic          cs,
   input  logic          wrn,
   input  logic [DW-1:0] din,
   output logic          drqn,
   output logic [LW-1:0] level,
   output logic          ovf
);
   localparam int PW = $clog2(DEPTH);
   localparam int HW = (DRQ_HOLD > 0) ? $clog2(DRQ_HOLD+1) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} st_t;

   st_t           st_q, st_d;
   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [LW-1:0] level_q, level_d;
   logic [AW-1:0] ha_q, ha_d, fa_q, fa_d, addr_q;
   logic [DW-1:0] head_q, head_d, push_data;
   logic [HW-1:0] hold_q, hold_d;
   logic          ovf_q, ovf_d, drqn_q, drqn_d, mdn_q, stb_q;
   logic          empty, full, achg, mode_chg, flush_int, seq, resync;
   logic          pop, push, m_push, s_push, stb, wr_edge;

   always_comb begin
      empty     = (level_q == '0);
      full      = (level_q == LW'(DEPTH));
      achg      = (ctrl_addr != addr_q);
      mode_chg  = (mdn != mdn_q);
      flush_int = flush | mode_chg;
      seq       = (ctrl_addr == ha_q + AW'(1));
      // Any address outside {ha, ha+1} means the sequencer jumped: restart fetching there
      resync    = mdn & (flush_int | (achg & ctrl_cs & (ctrl_addr != ha_q) & !seq));
      pop       = achg & ctrl_cs & !empty & (!mdn | seq) & !flush_int;
      stb       = cs & !wrn;
      wr_edge   = stb & !stb_q & !mdn;
      m_push    = mdn & (st_q == ST_REQ) & rom_ok & !resync;
      s_push    = wr_edge & !flush_int & !full;
      push      = m_push | s_push;
      push_data = mdn ? rom_data : din;
   end

   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      level_d = level_q;
      ha_d    = ha_q;
      fa_d    = fa_q;
      if (flush_int || resync) begin
         rd_d    = wr_q;
         level_d = '0;
      end else begin
         if (pop) begin
            rd_d = rd_q + PW'(1);
            ha_d = ha_q + AW'(1);
         end
         if (push) wr_d = wr_q + PW'(1);
         level_d = level_q + LW'(push) - LW'(pop);
      end
      if (resync) begin
         ha_d = ctrl_addr;
         fa_d = ctrl_addr;
      end else if (m_push) begin
         fa_d = fa_q + AW'(1);
      end
      // A push into an (about to be) empty FIFO bypasses the storage to the head
      head_d = (push && level_q == LW'(pop)) ? push_data : mem[rd_d];
   end

   always_comb begin
      ovf_d  = ovf_q;
      hold_d = hold_q;
      if (flush_int) begin
         ovf_d  = 1'b0;
         hold_d = '0;
      end else begin
         if (wr_edge && full) ovf_d = 1'b1;
         if (s_push) hold_d = HW'(DRQ_HOLD);
         else if (cen4 && hold_q != '0) hold_d = hold_q - HW'(1);
      end
      drqn_d = !(!mdn && ctrl_cs && !full && hold_q == '0 && !stb && !flush_int);
   end

   always_comb begin
      st_d = st_q;
      if (!mdn) begin
         st_d = ST_IDLE;
      end else if (resync) begin
         st_d = ST_GAP;
      end else begin
         case (st_q)
            ST_IDLE: if (ctrl_cs && !full) st_d = ST_REQ;
            ST_REQ:  if (rom_ok) st_d = ST_GAP;
            ST_GAP:  st_d = (ctrl_cs && !full) ? ST_REQ : ST_IDLE;
            default: st_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= push_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_q    <= ST_IDLE;
         rd_q    <= '0;
         wr_q    <= '0;
         level_q <= '0;
         ha_q    <= '0;
         fa_q    <= '0;
         addr_q  <= '0;
         head_q  <= '0;
         hold_q  <= '0;
         ovf_q   <= 1'b0;
         drqn_q  <= 1'b1;
         mdn_q   <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         level_q <= level_d;
         ha_q    <= ha_d;
         fa_q    <= fa_d;
         addr_q  <= ctrl_addr;
         head_q  <= head_d;
         hold_q  <= hold_d;
         ovf_q   <= ovf_d;
         drqn_q  <= drqn_d;
         mdn_q   <= mdn;
         stb_q   <= stb;
      end
   end

   assign ctrl_din = head_q;
   assign ctrl_ok  = !empty && !achg && (!mdn || ctrl_addr == ha_q);
   // The GAP state keeps rom_cs low one cycle so a late rom_ok never matches a new address
   assign rom_cs   = mdn && !mode_chg && (st_q == ST_REQ);
   assign rom_addr = fa_q;
   assign drqn     = drqn_q;
   assign level    = level_q;
   assign ovf      = ovf_q;
endmodule

// File: tb/tb_jt7759_dfifo.sv
// tb/tb_jt7759_dfifo.sv - directed self-checking bench for jt7759_dfifo
// A small ROM responder answers each rom_cs on its second cycle.
module tb_jt7759_dfifo;
   localparam int DW = 8;
   localparam int AW = 17;
   localparam int LW = 3;

   logic          clk, rstn, cen4, mdn, flush, ctrl_cs;
   logic [AW-1:0] ctrl_addr, rom_addr;
   logic [DW-1:0] ctrl_din, rom_data, din;
   logic          ctrl_ok, rom_cs, rom_ok, cs, wrn, drqn, ovf;
   logic [LW-1:0] level;

   int            n_chk = 0;
   int            n_err = 0;
   int            cyc_n = 0;
   int            req_cnt = 0;
   logic          rom_auto = 1'b0;
   logic [AW-1:0] fetched[$];
   int            fetch_cyc[$];

   jt7759_dfifo #(.DW(DW), .AW(AW), .DEPTH(4), .DRQ_HOLD(3)) u_dut (
      .clk(clk), .rstn(rstn), .cen4(cen4), .mdn(mdn), .flush(flush),
      .ctrl_cs(ctrl_cs), .ctrl_addr(ctrl_addr), .ctrl_din(ctrl_din), .ctrl_ok(ctrl_ok),
      .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
      .cs(cs), .wrn(wrn), .din(din), .drqn(drqn), .level(level), .ovf(ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
      return a[7:0] ^ a[16:9] ^ 8'h5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_level(input int tgt, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (level == LW'(tgt)) break;
      end
      chk(tag, 32'(level), tgt);
   endtask

   task automatic cpu_wr(input logic [DW-1:0] d, input int hold_cyc);
      din = d;
      cs  = 1'b1;
      wrn = 1'b0;
      repeat (hold_cyc) tick();
      cs  = 1'b0;
      wrn = 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc_n++;
         #1;
         if (rom_cs) req_cnt++;
         else req_cnt = 0;
         if (rom_auto) begin
            rom_ok   = rom_cs && (req_cnt == 2);
            rom_data = rom_fn(rom_addr);
            if (rom_ok) begin
               fetched.push_back(rom_addr);
               fetch_cyc.push_back(cyc_n);
            end
         end
      end
   end

   initial begin
      int hi_cnt;
      rstn = 1'b0; cen4 = 1'b1; mdn = 1'b1; flush = 1'b0; ctrl_cs = 1'b0;
      ctrl_addr = '0; rom_data = '0; rom_ok = 1'b0; cs = 1'b0; wrn = 1'b1; din = '0;
      repeat (2) tick();
      chk("rst_level", 32'(level), 0);
      chk("rst_ctrl_ok", 32'(ctrl_ok), 0);
      chk("rst_rom_cs", 32'(rom_cs), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      chk("rst_drqn", 32'(drqn), 1);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_ctrl_din", 32'(ctrl_din), 0);
      rstn = 1'b1;
      repeat (2) tick();

      // Master prefetch of 0x100..0x103
      ctrl_cs = 1'b1; ctrl_addr = 17'h00100; rom_auto = 1'b1;
      wait_level(4, 60, "m_fill_level");
      for (int i = 0; i < 4; i++) chk("m_fill_addr", 32'(fetched[i]), 32'h100 + i);
      for (int i = 1; i < 4; i++) chk("m_fill_spacing", fetch_cyc[i] - fetch_cyc[i-1], 3);
      hi_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rom_cs) hi_cnt++;
      end
      chk("m_full_rom_cs_idle", hi_cnt, 0);
      chk("m_full_level", 32'(level), 4);
      chk("m_head_ok", 32'(ctrl_ok), 1);
      chk("m_head_data", 32'(ctrl_din), 32'(rom_fn(17'h00100)));

      // Sequential consume
      ctrl_addr = 17'h00101;
      #1 chk("m_step1_ok_low", 32'(ctrl_ok), 0);
      tick();
      chk("m_step1_ok_high", 32'(ctrl_ok), 1);
      chk("m_step1_data", 32'(ctrl_din), 32'(rom_fn(17'h00101)));
      chk("m_step1_level", 32'(level), 3);
      ctrl_addr = 17'h00102;
      #1 chk("m_step2_ok_low", 32'(ctrl_ok), 0);
      tick();
      chk("m_step2_ok_high", 32'(ctrl_ok), 1);
      chk("m_step2_data", 32'(ctrl_din), 32'(rom_fn(17'h00102)));
      wait_level(4, 40, "m_refill_level");
      chk("m_refill_addr4", 32'(fetched[4]), 32'h104);
      chk("m_refill_addr5", 32'(fetched[5]), 32'h105);

      // Jump with a stale rom_ok in the resync cycle
      rom_auto = 1'b0; rom_ok = 1'b0;
      ctrl_addr = 17'h00103;
      repeat (2) tick();
      chk("m_jump_pre_rom_cs", 32'(rom_cs), 1);
      chk("m_jump_pre_rom_addr", 32'(rom_addr), 32'h106);
      ctrl_addr = 17'h1F000; rom_ok = 1'b1; rom_data = 8'hEE;
      tick();
      rom_ok = 1'b0;
      chk("m_jump_level", 32'(level), 0);
      chk("m_jump_ok", 32'(ctrl_ok), 0);
      chk("m_jump_gap", 32'(rom_cs), 0);
      tick();
      chk("m_jump_rom_cs", 32'(rom_cs), 1);
      chk("m_jump_rom_addr", 32'(rom_addr), 32'h1F000);
      rom_auto = 1'b1;
      wait_level(1, 20, "m_jump_fill");
      chk("m_jump_data", 32'(ctrl_din), 32'(rom_fn(17'h1F000)));
      chk("m_jump_data_ok", 32'(ctrl_ok), 1);

      // Fetch address wrap
      ctrl_addr = 17'h1FFFF;
      wait_level(1, 20, "m_wrap_fill");
      chk("m_wrap_fa", 32'(rom_addr), 0);
      chk("m_wrap_data", 32'(ctrl_din), 32'(rom_fn(17'h1FFFF)));
      chk("m_wrap_ok", 32'(ctrl_ok), 1);

      // Mode change drops rom_cs at once
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rom_cs) break;
      end
      chk("mode_pre_rom_cs", 32'(rom_cs), 1);
      mdn = 1'b0;
      #1 chk("mode_rom_cs_drop", 32'(rom_cs), 0);
      tick();
      rom_auto = 1'b0; rom_ok = 1'b0;
      chk("mode_level", 32'(level), 0);
      chk("mode_drqn", 32'(drqn), 1);
      tick();
      chk("s_idle_drqn", 32'(drqn), 0);

      // Slave writes and DRQ hold-off
      cpu_wr(8'hA1, 1);
      chk("s_w1_level", 32'(level), 1);
      chk("s_w1_drqn", 32'(drqn), 1);
      chk("s_w1_data", 32'(ctrl_din), 32'hA1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s_w1_hold", 32'(drqn), 1);
      end
      tick();
      chk("s_w1_release", 32'(drqn), 0);
      cen4 = 1'b0;
      cpu_wr(8'hA2, 1);
      repeat (5) tick();
      chk("s_w2_frozen", 32'(drqn), 1);
      cen4 = 1'b1;
      repeat (3) tick();
      chk("s_w2_hold", 32'(drqn), 1);
      tick();
      chk("s_w2_release", 32'(drqn), 0);
      cpu_wr(8'hA3, 3);
      chk("s_w3_single_push", 32'(level), 3);
      repeat (2) tick();
      chk("s_w3_release", 32'(drqn), 0);
      cpu_wr(8'hA4, 1);
      chk("s_w4_level", 32'(level), 4);
      repeat (6) tick();
      chk("s_full_drqn", 32'(drqn), 1);
      cpu_wr(8'hA5, 1);
      chk("s_w5_level", 32'(level), 4);
      chk("s_w5_ovf", 32'(ovf), 1);
      chk("s_head", 32'(ctrl_din), 32'hA1);
      chk("s_head_ok", 32'(ctrl_ok), 1);
      tick();

      // Slave pops, simultaneous push/pop, flush with write
      ctrl_addr = ctrl_addr + 17'd1;
      #1 chk("s_pop1_ok_low", 32'(ctrl_ok), 0);
      tick();
      chk("s_pop1_level", 32'(level), 3);
      chk("s_pop1_data", 32'(ctrl_din), 32'hA2);
      ctrl_addr = ctrl_addr + 17'd1;
      tick();
      chk("s_pop2_level", 32'(level), 2);
      chk("s_pop2_data", 32'(ctrl_din), 32'hA3);
      ctrl_addr = ctrl_addr + 17'd1;
      cpu_wr(8'hB1, 1);
      chk("s_simul_level", 32'(level), 2);
      chk("s_simul_data", 32'(ctrl_din), 32'hA4);
      chk("s_simul_ovf", 32'(ovf), 1);
      tick();
      ctrl_addr = ctrl_addr + 17'd1;
      tick();
      chk("s_order_data", 32'(ctrl_din), 32'hB1);
      chk("s_order_level", 32'(level), 1);
      flush = 1'b1;
      cpu_wr(8'hC1, 1);
      flush = 1'b0;
      chk("s_flush_level", 32'(level), 0);
      chk("s_flush_ovf", 32'(ovf), 0);
      chk("s_flush_drqn", 32'(drqn), 1);
      chk("s_flush_ok", 32'(ctrl_ok), 0);

      // Asynchronous reset during a ROM request
      mdn = 1'b1; rom_auto = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (level == 3'd3 && rom_cs) break;
      end
      chk("r_setup", 32'(level == 3'd3 && rom_cs), 1);
      rstn = 1'b0;
      #1;
      chk("r_rom_cs", 32'(rom_cs), 0);
      chk("r_drqn", 32'(drqn), 1);
      chk("r_level", 32'(level), 0);
      chk("r_ctrl_ok", 32'(ctrl_ok), 0);
      tick();
      chk("r_ctrl_din", 32'(ctrl_din), 0);
      chk("r_level_held", 32'(level), 0);
      rom_auto = 1'b0; rom_ok = 1'b0;
      rstn = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/jt7759_dfifo.md
Name: jt7759_dfifo

Overview:
Parametrised sample-data feeder between the jt7759 control/ADPCM sequencer and its data source. It replaces the single-byte latch with a DEPTH-entry FIFO.
- Master mode (mdn=1): an address-tracking prefetcher reads ROM ahead of the control block.
- Slave mode (mdn=0): the FIFO is filled by CPU writes, paced by a DRQ hold-off counter.

Parameters:
DW, 8, data width of ROM, CPU and control data paths
AW, 17, address width of ctrl_addr and rom_addr
DEPTH, 4, FIFO entries; power of two, >=2
DRQ_HOLD, 3, cen4 ticks drqn is kept high after each accepted CPU write
LW, $clog2(DEPTH+1), width of the level output (derived)

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock; asynchronous, active-low
cen4  in  1  clock enable; paces the DRQ hold-off counter
mdn  in  1  1=master (ROM) mode, 0=slave (CPU) mode
flush  in  1  one-cycle pulse from control at phrase start; empties FIFO
ctrl_cs  in  1  control block is requesting data
ctrl_addr  in  AW  address the control block wants
ctrl_din  out  DW  FIFO head data
ctrl_ok  out  1  ctrl_din is valid for ctrl_addr
rom_cs  out  1  ROM read request
rom_addr  out  AW  ROM read address
rom_data  in  DW  ROM data
rom_ok  in  1  rom_data valid for the current rom_addr
cs  in  1  CPU chip select
wrn  in  1  CPU write strobe, active-low
din  in  DW  CPU write data
drqn  out  1  data request to CPU, active-low
level  out  LW  current FIFO occupancy
ovf  out  1  sticky flag: CPU write dropped because FIFO full

Behaviour:
- Reset values (rstn=0): FIFO empty, level=0, ctrl_din=0, ctrl_ok=0, rom_cs=0, rom_addr=0, drqn=1, ovf=0, hold counter=0, head address ha=0, prefetch state IDLE.
- Storage: circular buffer with rd/wr pointers of $clog2(DEPTH) bits that wrap naturally; level is a separate counter. Full = level==DEPTH; empty = level==0.
- ctrl_din: the registered head entry.
- achg: ctrl_addr differs from its value registered on the previous cycle.
- Pop: on achg with ctrl_cs=1, the FIFO is not empty, and (slave mode, or master mode with ctrl_addr==ha+1). Effect: rd advances, level decrements, ha<=ha+1 (modulo 2^AW).
- Pop on empty: ignored; no state change.
- ctrl_ok:
  - master: !empty && ctrl_addr==ha && !achg
  - slave: !empty && !achg
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Master prefetcher states: IDLE, REQ, GAP.
  - Fetch address register fa.
  - IDLE->REQ when ctrl_cs=1 and FIFO not full; rom_cs=1 and rom_addr=fa in REQ.
  - In REQ, rom_ok=1: push rom_data, fa<=fa+1 (wraps at 2^AW), go to GAP.
  - GAP: rom_cs=0 for exactly one cycle so a stale rom_ok is never accepted. Then go to REQ if not full and ctrl_cs=1, else IDLE.
  - ctrl_cs=0: finish the current REQ, then go to IDLE.
- Resync (master): on achg with ctrl_cs=1 and ctrl_addr not equal to ha or ha+1, or on any flush.
  - FIFO emptied; fa<=ctrl_addr, ha<=ctrl_addr; go to GAP.
  - A rom_ok arriving in the resync cycle is discarded.
- Slave push: on the first cycle of cs=1 && wrn=0 (edge of the combined strobe); holding the strobe longer gives one push only.
  - If full: data dropped and ovf<=1.
  - Each accepted push loads hold<=DRQ_HOLD.
- Hold counter: decrements on cen4 while non-zero.
- drqn (registered): 0 only when mdn=0, ctrl_cs=1, not full, hold==0, and no push strobe this cycle. Otherwise 1. Always 1 in master mode.
- flush: empties FIFO, clears ovf and hold, forces drqn=1 for that cycle. A same-cycle CPU write or ROM data is dropped (flush wins; ovf not set).
- A change of mdn acts as an internal flush; rom_cs drops in the same cycle.
- Reset mid-ROM-request: rom_cs drops asynchronously; no push from a pending rom_ok.

Test Plan:
- Master, DEPTH=4: ctrl_cs=1, ctrl_addr=0x100, rom_ok 1 cycle after each rom_cs -> rom_addr 0x100..0x103 fetched with a 1-cycle rom_cs gap between each; level reaches 4 then rom_cs stays 0; ctrl_ok=1 with ctrl_din=ROM[0x100].
- Master sequential consume: ctrl_addr steps 0x100->0x101->0x102 -> one pop per step; ctrl_ok low exactly one cycle per step; prefetcher refills to address 0x104, 0x105.
- Master jump: ctrl_addr 0x101->0x1F000 -> FIFO emptied, next rom_addr=0x1F000; rom_ok in the jump cycle ignored. Also fa=0x1FFFF wraps to 0x00000.
- Slave DEPTH=4, DRQ_HOLD=3: 5 CPU writes 0xA1..0xA5 while ctrl_cs=1, no pops -> drqn high for 3 cen4 ticks after each write; drqn stays 1 when level=4; 5th write dropped, ovf=1; ctrl_din=0xA1.
- Slave simultaneous: write accepted in the same cycle as an achg pop at level=2 -> level stays 2, data order preserved. flush with a same-cycle write -> level=0, ovf=0.
- Reset: rstn low while rom_cs=1 and level=3 -> rom_cs=0, drqn=1, level=0, ctrl_ok=0 immediately, without waiting for a clock edge.
